// File: rtl/pconv_sched_c6_if.sv
//------------------------------------------------------------------------------
// pconv_sched_c6_if
//
// Bundles every signal between the pointwise-convolution sequencer and its
// surroundings: the start/busy/done control handshake, the feature RAM and
// weight/bias/shift ROM read ports, the link to the 6-channel convolution unit
// and the output buffer write port.
//
//   master : the sequencer side (drives read strobes, unit inputs, writes)
//   slave  : the environment side (controller, RAMs/ROMs, unit, out buffer)
//
// Parameters must match the ones given to pconv_sched_c6.
//------------------------------------------------------------------------------
interface pconv_sched_c6_if #(
    parameter int N      = 16,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int OUT_CH = 12
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OC_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int OUT_AW = (NPIX * OUT_CH > 1) ? $clog2(NPIX * OUT_CH) : 1;

    // control handshake
    logic              start;
    logic              busy;
    logic              done;
    // feature RAM and weight/bias/shift ROMs
    logic              fm_rd_en;
    logic [PIX_W-1:0]  fm_rd_addr;
    logic [6*N-1:0]    fm_rd_data;
    logic [OC_W-1:0]   w_rd_addr;
    logic [6*N-1:0]    w_rd_data;
    logic [31:0]       b_rd_data;
    logic [4:0]        s_rd_data;
    // convolution unit
    logic              unit_vld;
    logic [6*N-1:0]    unit_input;
    logic [6*N-1:0]    unit_weight;
    logic [31:0]       unit_bias;
    logic [4:0]        unit_shift;
    logic [N-1:0]      unit_dout;
    logic              unit_dout_vld;
    // output buffer
    logic              out_wr_en;
    logic [OUT_AW-1:0] out_wr_addr;
    logic [N-1:0]      out_wr_data;
    logic              err_tag;

    modport master (
        input  start, fm_rd_data, w_rd_data, b_rd_data, s_rd_data,
               unit_dout, unit_dout_vld,
        output busy, done, fm_rd_en, fm_rd_addr, w_rd_addr,
               unit_vld, unit_input, unit_weight, unit_bias, unit_shift,
               out_wr_en, out_wr_addr, out_wr_data, err_tag
    );

    modport slave (
        output start, fm_rd_data, w_rd_data, b_rd_data, s_rd_data,
               unit_dout, unit_dout_vld,
        input  busy, done, fm_rd_en, fm_rd_addr, w_rd_addr,
               unit_vld, unit_input, unit_weight, unit_bias, unit_shift,
               out_wr_en, out_wr_addr, out_wr_data, err_tag
    );
endinterface

// File: rtl/pconv_sched_c6.sv
//------------------------------------------------------------------------------
// pconv_sched_c6
//
// Sequencer for the 6-channel pointwise convolution unit. Walks the feature
// map pixel by pixel and, at every pixel, steps through all output channels.
// Each (pixel, channel) pair issues one read of the input word and of the
// channel's weight/bias/shift; one cycle later the data reaches the unit with
// unit_vld. The output address (channel-major: oc*NPIX + pix) travels through
// a tag FIFO and is reunited with the unit's result when it comes back.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - pconv_sched_c6_if.master: start/busy/done, RAM/ROM reads, unit
//          link, output buffer write and sticky err_tag
//------------------------------------------------------------------------------
module pconv_sched_c6 #(
    parameter int N          = 16,
    parameter int IMG_W      = 24,
    parameter int IMG_H      = 24,
    parameter int OUT_CH     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pconv_sched_c6_if.master     bus
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OC_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int OUT_AW = (NPIX * OUT_CH > 1) ? $clog2(NPIX * OUT_CH) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [OC_W-1:0]   OC_LAST  = OC_W'(OUT_CH - 1);
    localparam logic [OUT_AW-1:0] NPIX_A   = OUT_AW'(NPIX);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [PIX_W-1:0]   pix_q;
    logic [OC_W-1:0]    oc_q;
    logic               busy_q;
    logic               done_q;

    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               unit_vld_q;
    logic [OUT_AW-1:0]  tag_q;

    logic [OUT_AW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;

    logic               wr_en_q;
    logic [OUT_AW-1:0]  wr_addr_q;
    logic [N-1:0]       wr_data_q;
    logic               err_q;

    logic               issue;
    logic               last_issue;
    logic               dec;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [OUT_AW-1:0]  tag_d;

    // Issue gating looks only at the registered inflight count, so at most
    // FIFO_DEPTH tags can ever be outstanding and the tag FIFO cannot overflow.
    assign issue      = (state_q == S_RUN) && (inflight_q < DEPTH_C);
    assign last_issue = issue && (pix_q == PIX_LAST) && (oc_q == OC_LAST);
    assign tag_d      = OUT_AW'(oc_q) * NPIX_A + OUT_AW'(pix_q);

    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = unit_vld_q;
    assign pop        = bus.unit_dout_vld && !fifo_empty;
    // A result with no tag waiting never drags inflight below zero.
    assign dec        = bus.unit_dout_vld && (inflight_q != '0);

    always_comb begin
        // NOTE: give every always_comb target a default first; a path that
        // leaves it unassigned would infer a latch.
        inflight_d = inflight_q;
        if (issue && !dec) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && dec) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Control FSM: walks (pix, oc) during RUN, waits for the tail of results
    // in DRAIN and emits a one-cycle done from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            oc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        pix_q   <= '0;
                        oc_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (oc_q == OC_LAST) begin
                            oc_q  <= '0;
                            pix_q <= last_issue ? '0 : pix_q + PIX_W'(1);
                        end else begin
                            oc_q <= oc_q + OC_W'(1);
                        end
                        if (last_issue) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // A result arriving now still owes a write next cycle.
                    if ((inflight_q == '0) && !bus.unit_dout_vld) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Issue pipeline, inflight tracking, tag FIFO pointers and the output
    // write register. err_tag watches for any result that finds no tag; the
    // unit is expected to share this reset, so no stale result survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            unit_vld_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            unit_vld_q <= issue;
            if (issue) begin
                tag_q <= tag_d;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                wr_addr_q <= fifo_mem[rd_ptr_q];
                wr_data_q <= bus.unit_dout;
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            wr_en_q    <= pop;
            if (bus.unit_dout_vld && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: tag storage has no reset; emptiness is defined by the pointers and
    // count, which are reset, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tag_q;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fm_rd_en    = issue;
    assign bus.fm_rd_addr  = pix_q;
    assign bus.w_rd_addr   = oc_q;
    assign bus.unit_vld    = unit_vld_q;
    assign bus.unit_input  = bus.fm_rd_data;
    assign bus.unit_weight = bus.w_rd_data;
    assign bus.unit_bias   = bus.b_rd_data;
    assign bus.unit_shift  = bus.s_rd_data;
    assign bus.out_wr_en   = wr_en_q;
    assign bus.out_wr_addr = wr_addr_q;
    assign bus.out_wr_data = wr_data_q;
    assign bus.err_tag     = err_q;

endmodule
